rvc_asap_5pl_dmem_arb: RTL and testbench

Two-master arbiter for the 5-stage core's data memory port. It shares the single synchronous D_MEM access between the core's Q103H load/store stream and an external debug/loader master. The core is stalled whenever it loses arbitration. Sits between the core's Q103H memory signals and the memory wrapper's D_MEM inputs, and steers the Q104H read data back to the owning master.

---
 rtl/rvc_asap_pkg.sv | 5 +
 rtl/rvc_asap_5pl_dmem_arb_starve.sv | 30 +++
 rtl/rvc_asap_5pl_dmem_arb.sv | 73 +++++++
 tb/tb_rvc_asap_5pl_dmem_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared types and constants for the rvc_asap 5-stage core data-memory arbiter.
package rvc_asap_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} t_dmem_owner;
  localparam int DMEM_ARB_MAX_WAIT_DFLT = 8;
endpackage

// File: rtl/rvc_asap_5pl_dmem_arb_starve.sv
// rvc_asap_5pl_dmem_arb_starve: debug starvation guard (wait counter, force flag, core-first flag).
// Only instantiated when RVC_DMEM_ARB_FAIR_EN is defined.
module rvc_asap_5pl_dmem_arb_starve
  import rvc_asap_pkg::*;
#(
  parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_valid,
  input  logic dbg_gnt,
  input  logic core_gnt,
  output logic force_dbg
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] wait_cnt;
  logic core_first_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      core_first_q <= 1'b0;
    end else begin
      wait_cnt     <= (!dbg_valid || dbg_gnt) ? '0 :
                      (wait_cnt == W'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
      // After a forced grant the core gets the next slot before another force can happen
      core_first_q <= (dbg_gnt && force_dbg) ? 1'b1 : core_gnt ? 1'b0 : core_first_q;
    end
  end
  assign force_dbg = (wait_cnt == W'(MAX_WAIT)) && !core_first_q;
endmodule

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// rvc_asap_5pl_dmem_arb: core/debug arbiter for the single D_MEM port with Q104H read-data steering.
// Define RVC_DMEM_ARB_FAIR_EN for bounded debug latency; otherwise the core has strict priority.
module rvc_asap_5pl_dmem_arb
  import rvc_asap_pkg::*;
#(
  parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DFLT
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        CoreReqQ103H,
  input  logic        CoreWrEnQ103H,
  input  logic [31:0] CoreAddrQ103H,
  input  logic [31:0] CoreWrDataQ103H,
  input  logic [3:0]  CoreByteEnQ103H,
  output logic        CoreStall,
  output logic [31:0] CoreRdDataQ104H,
  input  logic        DbgReqValid,
  output logic        DbgReqReady,
  input  logic        DbgWrEn,
  input  logic [31:0] DbgAddr,
  input  logic [31:0] DbgWrData,
  input  logic [3:0]  DbgByteEn,
  output logic        DbgRspValid,
  output logic [31:0] DbgRspData,
  output logic        MemRdEn,
  output logic        MemWrEn,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWrData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRdDataQ104H
);
  logic core_gnt, dbg_gnt, force_dbg, dbg_wr_q;
  t_dmem_owner last_own_q;
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end
`ifdef RVC_DMEM_ARB_FAIR_EN
  rvc_asap_5pl_dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (Clock),
    .rst_n     (Rst),
    .dbg_valid (DbgReqValid),
    .dbg_gnt   (dbg_gnt),
    .core_gnt  (core_gnt),
    .force_dbg (force_dbg)
  );
`else
  assign force_dbg = 1'b0;
`endif
  always_comb begin
    dbg_gnt   = Rst && DbgReqValid && (!CoreReqQ103H || force_dbg);
    core_gnt  = Rst && CoreReqQ103H && !dbg_gnt;
    MemRdEn   = (core_gnt && !CoreWrEnQ103H) || (dbg_gnt && !DbgWrEn);
    MemWrEn   = (core_gnt && CoreWrEnQ103H) || (dbg_gnt && DbgWrEn);
    MemAddr   = core_gnt ? CoreAddrQ103H : dbg_gnt ? DbgAddr : '0;
    MemWrData = core_gnt ? CoreWrDataQ103H : dbg_gnt ? DbgWrData : '0;
    MemByteEn = core_gnt ? CoreByteEnQ103H : dbg_gnt ? DbgByteEn : '0;
  end
  assign CoreStall   = Rst && CoreReqQ103H && !core_gnt;
  assign DbgReqReady = dbg_gnt;
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      last_own_q <= OWN_NONE;
      dbg_wr_q   <= 1'b0;
    end else begin
      last_own_q <= dbg_gnt ? OWN_DBG : core_gnt ? OWN_CORE : OWN_NONE;
      dbg_wr_q   <= DbgWrEn;
    end
  end
  // Gating with Rst drops a response that is in flight when reset arrives
  assign CoreRdDataQ104H = (Rst && last_own_q == OWN_CORE) ? MemRdDataQ104H : '0;
  assign DbgRspValid     = Rst && last_own_q == OWN_DBG;
  assign DbgRspData      = (DbgRspValid && !dbg_wr_q) ? MemRdDataQ104H : '0;
endmodule

// File: tb/tb_rvc_asap_5pl_dmem_arb.sv
// tb_rvc_asap_5pl_dmem_arb: scoreboard bench for the D_MEM arbiter with a small synchronous memory model.
module tb_rvc_asap_5pl_dmem_arb;
`ifdef RVC_DMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic        Clock, Rst;
  logic        CoreReqQ103H, CoreWrEnQ103H;
  logic [31:0] CoreAddrQ103H, CoreWrDataQ103H;
  logic [3:0]  CoreByteEnQ103H;
  logic        CoreStall;
  logic [31:0] CoreRdDataQ104H;
  logic        DbgReqValid, DbgReqReady, DbgWrEn;
  logic [31:0] DbgAddr, DbgWrData;
  logic [3:0]  DbgByteEn;
  logic        DbgRspValid;
  logic [31:0] DbgRspData;
  logic        MemRdEn, MemWrEn;
  logic [31:0] MemAddr, MemWrData;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRdDataQ104H;
  logic [31:0] mem [256];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int due; logic [31:0] d;} exp_t;
  exp_t core_q[$];
  exp_t dbg_q[$];
  exp_t e;

  rvc_asap_5pl_dmem_arb #(.MAX_WAIT(8)) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReqQ103H(CoreReqQ103H), .CoreWrEnQ103H(CoreWrEnQ103H), .CoreAddrQ103H(CoreAddrQ103H),
    .CoreWrDataQ103H(CoreWrDataQ103H), .CoreByteEnQ103H(CoreByteEnQ103H),
    .CoreStall(CoreStall), .CoreRdDataQ104H(CoreRdDataQ104H),
    .DbgReqValid(DbgReqValid), .DbgReqReady(DbgReqReady), .DbgWrEn(DbgWrEn), .DbgAddr(DbgAddr),
    .DbgWrData(DbgWrData), .DbgByteEn(DbgByteEn), .DbgRspValid(DbgRspValid), .DbgRspData(DbgRspData),
    .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemByteEn(MemByteEn), .MemRdDataQ104H(MemRdDataQ104H)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) begin
    if (MemWrEn)
      for (int b = 0; b < 4; b++)
        if (MemByteEn[b]) mem[MemAddr[9:2]][8*b +: 8] <= MemWrData[8*b +: 8];
    if (MemRdEn) MemRdDataQ104H <= mem[MemAddr[9:2]];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", n, cyc, act, exp);
    end
  endtask

  task automatic push_core(input logic [31:0] d);
    core_q.push_back('{due: cyc + 1, d: d});
  endtask

  task automatic push_dbg(input logic [31:0] d);
    dbg_q.push_back('{due: cyc + 1, d: d});
  endtask

  task automatic core(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be);
    CoreReqQ103H = req; CoreWrEnQ103H = we; CoreAddrQ103H = a; CoreWrDataQ103H = wd; CoreByteEnQ103H = be;
  endtask

  task automatic dbg(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be);
    DbgReqValid = v; DbgWrEn = we; DbgAddr = a; DbgWrData = wd; DbgByteEn = be;
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_ready"}, DbgReqReady, 0);
    chk({n, "_stall"}, CoreStall, 0);
    chk({n, "_rden"}, MemRdEn, 0);
    chk({n, "_wren"}, MemWrEn, 0);
  endtask

  task automatic contention(input bit rel);
    bit pend = 1'b1;
    bit f;
    int lim = FAIR ? 10 : 100;
    for (int k = 1; k <= lim; k++) begin
      @(negedge Clock);
      if (rel && k == 1) Rst = 1'b1;
      core(1, 0, 32'h100, 0, 4'hF);
      dbg(pend, 0, 32'h200, 0, 4'hF);
      #2;
      f = FAIR && k == 9;
      chk("ctn_ready", DbgReqReady, f);
      chk("ctn_stall", CoreStall, f);
      chk("ctn_addr", MemAddr, f ? 32'h200 : 32'h100);
      push_core(f ? 32'h0 : 32'hDEAD_BEEF);
      if (f) begin
        push_dbg(32'h1234_5678);
        pend = 1'b0;
      end
    end
    if (!FAIR) begin
      @(negedge Clock);
      core(0, 0, 0, 0, 0);
      dbg(1, 0, 32'h200, 0, 4'hF);
      #2;
      chk("ctn_idle_ready", DbgReqReady, 1);
      chk("ctn_idle_stall", CoreStall, 0);
      push_dbg(32'h1234_5678);
      push_core(0);
    end
    @(negedge Clock);
    core(0, 0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    #2;
    push_core(0);
  endtask

  always @(negedge Clock) begin
    #1;
    if (core_q.size() > 0 && core_q[0].due == cyc) begin
      e = core_q.pop_front();
      chk("core_rd_data", CoreRdDataQ104H, e.d);
    end
    if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
      e = dbg_q.pop_front();
      chk("dbg_rsp_valid", DbgRspValid, 1);
      chk("dbg_rsp_data", DbgRspData, e.d);
    end else begin
      chk("dbg_rsp_idle", DbgRspValid, 0);
    end
  end

  initial begin
    Rst = 1'b0;
    core(0, 0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    @(negedge Clock);
    core(1, 0, 32'h100, 0, 4'hF);
    dbg(1, 0, 32'h200, 0, 4'hF);
    #2;
    chk_quiet("rst");
    push_core(0);
    // preload memory through the debug port; the core is idle
    @(negedge Clock);
    Rst = 1'b1;
    core(0, 0, 0, 0, 0);
    dbg(1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    #2;
    chk("dw0_ready", DbgReqReady, 1);
    chk("dw0_wren", MemWrEn, 1);
    push_dbg(0);
    push_core(0);
    @(negedge Clock);
    dbg(1, 1, 32'h104, 32'h0, 4'hF);
    #2;
    chk("dw1_ready", DbgReqReady, 1);
    push_dbg(0);
    @(negedge Clock);
    dbg(1, 1, 32'h200, 32'h1234_5678, 4'hF);
    #2;
    chk("dw2_ready", DbgReqReady, 1);
    chk("dw2_wren", MemWrEn, 1);
    chk("dw2_addr", MemAddr, 32'h200);
    chk("dw2_wdata", MemWrData, 32'h1234_5678);
    chk("dw2_be", MemByteEn, 4'hF);
    push_dbg(0);
    @(negedge Clock);
    dbg(0, 0, 0, 0, 0);
    core(1, 0, 32'h100, 0, 4'hF);
    #2;
    chk("cl_rden", MemRdEn, 1);
    chk("cl_stall", CoreStall, 0);
    chk("cl_addr", MemAddr, 32'h100);
    chk("cl_ready", DbgReqReady, 0);
    push_core(32'hDEAD_BEEF);
    @(negedge Clock);
    core(0, 0, 0, 0, 0);
    dbg(1, 0, 32'h200, 0, 4'hF);
    #2;
    chk("dr0_ready", DbgReqReady, 1);
    chk("dr0_rden", MemRdEn, 1);
    push_dbg(32'h1234_5678);
    push_core(0);
    @(negedge Clock);
    dbg(1, 0, 32'h100, 0, 4'hF);
    #2;
    chk("dr1_ready", DbgReqReady, 1);
    push_dbg(32'hDEAD_BEEF);
    @(negedge Clock);
    dbg(0, 0, 0, 0, 0);
    core(1, 1, 32'h104, 32'hAABB_CCDD, 4'h3);
    #2;
    chk("cs_wren", MemWrEn, 1);
    chk("cs_rden", MemRdEn, 0);
    chk("cs_be", MemByteEn, 4'h3);
    chk("cs_wdata", MemWrData, 32'hAABB_CCDD);
    @(negedge Clock);
    core(1, 0, 32'h104, 0, 4'hF);
    #2;
    chk("cl2_addr", MemAddr, 32'h104);
    push_core(32'h0000_CCDD);
    @(negedge Clock);
    core(0, 0, 0, 0, 0);
    #2;
    chk("idle_rden", MemRdEn, 0);
    chk("idle_wren", MemWrEn, 0);
    chk("idle_addr", MemAddr, 0);
    chk("idle_wdata", MemWrData, 0);
    push_core(0);
    contention(1'b0);
    // partial wait under core traffic, then reset must restart the wait count
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      core(1, 0, 32'h100, 0, 4'hF);
      dbg(1, 0, 32'h200, 0, 4'hF);
      #2;
      chk("pw_ready", DbgReqReady, 0);
      push_core(k == 5 ? 32'h0 : 32'hDEAD_BEEF);
    end
    @(negedge Clock);
    Rst = 1'b0;
    #2;
    chk_quiet("rst_pw");
    push_core(0);
    contention(1'b1);
    // reset right after a debug read grant drops the response
    @(negedge Clock);
    dbg(1, 0, 32'h100, 0, 4'hF);
    #2;
    chk("dr_rst_ready", DbgReqReady, 1);
    push_core(0);
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      Rst = 1'b0;
      dbg(0, 0, 0, 0, 0);
      core(1, 0, 32'h100, 0, 4'hF);
      #2;
      chk_quiet("rst_dr");
      chk("rst_dr_core_data", CoreRdDataQ104H, 0);
      push_core(0);
    end
    @(negedge Clock);
    Rst = 1'b1;
    core(0, 0, 0, 0, 0);
    #2;
    chk("rel_rden", MemRdEn, 0);
    @(negedge Clock);
    dbg(1, 0, 32'h200, 0, 4'hF);
    #2;
    chk("rel_dr_ready", DbgReqReady, 1);
    push_dbg(32'h1234_5678);
    push_core(0);
    @(negedge Clock);
    dbg(0, 0, 0, 0, 0);
    repeat (3) @(negedge Clock);
    #3;
    chk("scoreboard_drained", core_q.size() + dbg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
